mlcsub_stream: RTL

Word-serial multi-precision subtractor computing D = A − B − bin over NUM_WORDS words of WORD_W bits, least-significant word first. It is the inverse arithmetic end of the carry-lookahead adder datapath. It performs the final conditional subtraction and borrow detection of the IDDMM Montgomery loop on 4096-bit operands. Operand words stream in and difference words stream out over valid/ready handshakes. Borrow propagates through a registered chain between words.

---
 rtl/mlcsub_stream.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mlcsub_stream.sv
`default_nettype none
// mlcsub_stream: word-serial multi-precision subtractor D = A - B - bin, LS word first, valid/ready streams.
// Optional SUB_ZERO_DETECT_EN adds a 'zero' output flagging an all-zero difference.
module mlcsub_stream #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] d_word,
  output logic              out_last,
  output logic              done,
  output logic              borrow_out,
`ifdef SUB_ZERO_DETECT_EN
  output logic              zero,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic [WORD_W-1:0] d_word_q, d_word_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              borrow_out_q, borrow_out_d;
`ifdef SUB_ZERO_DETECT_EN
  logic              nz_q, nz_d;
  logic              zero_q, zero_d;
`endif

  logic              accept;
  logic              xfer;
  logic [WORD_W:0]   diff;

  // Extra MSB of the (WORD_W+1)-bit difference is the borrow into the next word.
  assign diff     = {1'b0, a_word} - {1'b0, b_word} - {{WORD_W{1'b0}}, borrow_q};
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    d_word_d     = d_word_q;
    out_last_d   = out_last_q;
    borrow_out_d = borrow_out_q;
    out_valid_d  = xfer ? 1'b0 : out_valid_q;
`ifdef SUB_ZERO_DETECT_EN
    nz_d         = nz_q;
    zero_d       = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          borrow_d     = bin;
          cnt_d        = '0;
          borrow_out_d = 1'b0;
`ifdef SUB_ZERO_DETECT_EN
          nz_d         = 1'b0;
          zero_d       = 1'b0;
`endif
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          d_word_d    = diff[WORD_W-1:0];
          borrow_d    = diff[WORD_W];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == LAST_CNT);
          cnt_d       = cnt_q + CNT_W'(1);
`ifdef SUB_ZERO_DETECT_EN
          nz_d        = nz_q | (|diff[WORD_W-1:0]);
`endif
          if (cnt_q == LAST_CNT) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Publish the final flags as we enter DONE so they are visible alongside done.
        if (xfer) begin
          borrow_out_d = borrow_q;
`ifdef SUB_ZERO_DETECT_EN
          zero_d       = ~nz_q;
`endif
          state_d      = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      d_word_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SUB_ZERO_DETECT_EN
      nz_q         <= 1'b0;
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      d_word_q     <= d_word_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      borrow_out_q <= borrow_out_d;
`ifdef SUB_ZERO_DETECT_EN
      nz_q         <= nz_d;
      zero_q       <= zero_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign d_word     = d_word_q;
  assign out_last   = out_last_q;
  assign borrow_out = borrow_out_q;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
`ifdef SUB_ZERO_DETECT_EN
  assign zero       = zero_q;
`endif

endmodule
`default_nettype wire
